// File: rtl/lbus_pkg.sv
// lbus_pkg: shared constants, FSM state encoding and beat-address helper for
// the line-bus responder (lbus_resp) and its pending write buffer (lbus_wbuf).
package lbus_pkg;

    localparam int LINE_W = 1024;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int OFFS_W = 7;
    localparam int LNUM_W = 64 - OFFS_W;

    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BEAT = 2'd1,
        ST_RD_BEAT = 2'd2,
        ST_RD_DONE = 2'd3
    } lbus_state_e;

    // Byte address of beat idx within the line numbered line_num.
    function automatic logic [63:0] beat_addr(input logic [LNUM_W-1:0] line_num,
                                              input logic [3:0]        idx);
        return {line_num, idx, 3'b000};
    endfunction

endpackage

// File: rtl/lbus_wbuf.sv
// lbus_wbuf: one-entry pending write-line buffer.
// A rising edge on wr captures the line number; the line data is captured on
// the following edge, after which the entry becomes valid. A rise while the
// entry is occupied (or still capturing) is dropped and sets the sticky ovf.
// Ports:
//   clk, clr_n      clock, async active-low reset
//   wr              write request from the cache (edge detected here)
//   line_in         line number (address bits above the line offset)
//   data_in         line data, valid the cycle after wr rises
//   pop             consume the valid entry
//   valid           entry holds a complete line
//   hold            a capture is starting or in progress
//   line_out/data_out buffered entry
//   ovf             sticky overflow flag
module lbus_wbuf #(
    parameter int LN_W   = 57,
    parameter int DATA_W = 1024
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              wr,
    input  logic [LN_W-1:0]   line_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic              valid,
    output logic              hold,
    output logic [LN_W-1:0]   line_out,
    output logic [DATA_W-1:0] data_out,
    output logic              ovf
);

    logic wr_q_r;
    logic cap_r;
    logic rise_s;
    logic busy_s;

    assign rise_s = wr & ~wr_q_r;
    // An entry being popped this edge counts as free.
    assign busy_s = (valid & ~pop) | cap_r;
    assign hold   = cap_r | rise_s;

    // Edge detect, two-phase capture, pop and sticky overflow.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_q_r   <= 1'b0;
            cap_r    <= 1'b0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            line_out <= '0;
            data_out <= '0;
        end else begin
            wr_q_r <= wr;
            if (rise_s) begin
                if (busy_s) begin
                    ovf <= 1'b1;
                end else begin
                    line_out <= line_in;
                    cap_r    <= 1'b1;
                end
            end
            if (cap_r) begin
                data_out <= data_in;
                valid    <= 1'b1;
                cap_r    <= 1'b0;
            end else if (pop) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lbus_resp.sv
// lbus_resp: memory-side responder for the 1024-bit cache line bus.
// Fills are assembled from 16 ascending 64-bit reads; write-through lines are
// drained as 16 ascending 64-bit writes. Pending writes take priority over
// reads so a read never overtakes an earlier write.
// Ports:
//   clk, clr_n                 clock, async active-low reset
//   b_addr, b_rd, b_wr         cache request side (b_addr[6:0] ignored)
//   b_data_in                  write line (valid the cycle after b_wr rises)
//   b_dv, b_data_out           fill valid pulse and assembled line
//   m_req, m_we, m_addr, m_wdata  registered memory beat request
//   m_rdata, m_ack             memory read data and beat completion
//   wr_ovf                     sticky: a write request was dropped
module lbus_resp
    import lbus_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_rd,
    output logic              b_dv,
    output logic [LINE_W-1:0] b_data_out,
    input  logic              b_wr,
    input  logic [LINE_W-1:0] b_data_in,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [BEAT_W-1:0] m_wdata,
    input  logic [BEAT_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              wr_ovf
);

    localparam int LN_W = ADDR_W - OFFS_W;

    lbus_state_e       state_r;
    logic [3:0]        beat_r;
    logic [3:0]        beat_nx_s;
    logic [LN_W-1:0]   rd_line_r;
    logic [LN_W-1:0]   wr_line_r;
    logic [LINE_W-1:0] wr_data_r;
    logic [LN_W-1:0]   b_line_s;
    logic [LN_W-1:0]   wb_line_s;
    logic [LINE_W-1:0] wb_data_s;
    logic              wb_valid_s;
    logic              wb_hold_s;
    logic              wb_pop_s;
    logic              unused_s;

    assign b_line_s  = b_addr[ADDR_W-1:OFFS_W];
    assign beat_nx_s = beat_r + 4'd1;
    assign wb_pop_s  = (state_r == ST_IDLE) && wb_valid_s;
    assign unused_s  = ^b_addr[OFFS_W-1:0];

    function automatic logic [ADDR_W-1:0] line_beat_addr(input logic [LN_W-1:0] ln,
                                                         input logic [3:0]      idx);
        return ADDR_W'(beat_addr(LNUM_W'(ln), idx));
    endfunction

    lbus_wbuf #(
        .LN_W   (LN_W),
        .DATA_W (LINE_W)
    ) u_wbuf (
        .clk      (clk),
        .clr_n    (clr_n),
        .wr       (b_wr),
        .line_in  (b_line_s),
        .data_in  (b_data_in),
        .pop      (wb_pop_s),
        .valid    (wb_valid_s),
        .hold     (wb_hold_s),
        .line_out (wb_line_s),
        .data_out (wb_data_s),
        .ovf      (wr_ovf)
    );

    // Main FSM with registered memory request, fill line and b_dv.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r    <= ST_IDLE;
            beat_r     <= 4'd0;
            rd_line_r  <= '0;
            wr_line_r  <= '0;
            wr_data_r  <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            b_dv       <= 1'b0;
            b_data_out <= '0;
        end else begin
            b_dv <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    beat_r <= 4'd0;
                    if (wb_valid_s) begin
                        wr_line_r <= wb_line_s;
                        wr_data_r <= wb_data_s;
                        m_req     <= 1'b1;
                        m_we      <= 1'b1;
                        m_addr    <= line_beat_addr(wb_line_s, 4'd0);
                        m_wdata   <= wb_data_s[BEAT_W-1:0];
                        state_r   <= ST_WR_BEAT;
                    end else if (b_rd && !wb_hold_s) begin
                        // A write capture in flight blocks the read so it drains first.
                        rd_line_r <= b_line_s;
                        m_req     <= 1'b1;
                        m_we      <= 1'b0;
                        m_addr    <= line_beat_addr(b_line_s, 4'd0);
                        state_r   <= ST_RD_BEAT;
                    end else begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                    end
                end
                ST_WR_BEAT: begin
                    if (m_ack) begin
                        if (beat_r == LAST_BEAT) begin
                            m_req   <= 1'b0;
                            m_we    <= 1'b0;
                            beat_r  <= 4'd0;
                            state_r <= ST_IDLE;
                        end else begin
                            beat_r  <= beat_nx_s;
                            m_addr  <= line_beat_addr(wr_line_r, beat_nx_s);
                            m_wdata <= wr_data_r[BEAT_W*int'(beat_nx_s) +: BEAT_W];
                        end
                    end
                end
                ST_RD_BEAT: begin
                    if (m_ack) begin
                        b_data_out[BEAT_W*int'(beat_r) +: BEAT_W] <= m_rdata;
                        if (!b_rd) begin
                            // Withdrawn request: the outstanding beat is done, stop here.
                            m_req   <= 1'b0;
                            beat_r  <= 4'd0;
                            state_r <= ST_IDLE;
                        end else if (beat_r == LAST_BEAT) begin
                            m_req   <= 1'b0;
                            b_dv    <= (b_line_s == rd_line_r);
                            state_r <= ST_RD_DONE;
                        end else begin
                            beat_r <= beat_nx_s;
                            m_addr <= line_beat_addr(rd_line_r, beat_nx_s);
                        end
                    end
                end
                ST_RD_DONE: begin
                    beat_r <= 4'd0;
                    if (b_rd && (b_line_s != rd_line_r)) begin
                        // Cache moved to another line: refetch from beat 0.
                        rd_line_r <= b_line_s;
                        m_req     <= 1'b1;
                        m_we      <= 1'b0;
                        m_addr    <= line_beat_addr(b_line_s, 4'd0);
                        state_r   <= ST_RD_BEAT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    m_req   <= 1'b0;
                    m_we    <= 1'b0;
                    beat_r  <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbus_resp.sv
// tb_lbus_resp: directed/randomized self-checking bench for lbus_resp.
// Memory model: read data at byte address a is a >> 3; every accepted beat is
// logged and compared with the sequence the line-bus rules require.
module tb_lbus_resp;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic [63:0]   b_addr = '0;
    logic          b_rd = 1'b0;
    logic          b_dv;
    logic [1023:0] b_data_out;
    logic          b_wr = 1'b0;
    logic [1023:0] b_data_in = '0;
    logic          m_req;
    logic          m_we;
    logic [63:0]   m_addr;
    logic [63:0]   m_wdata;
    logic [63:0]   m_rdata;
    logic          m_ack = 1'b0;
    logic          wr_ovf;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } beat_t;

    beat_t log_q[$];
    int    checks = 0;
    int    errors = 0;
    int    dv_cnt = 0;
    int    stab_viol = 0;
    int    ack_mode = 0;
    int    cyc = 0;

    lbus_resp dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .b_addr     (b_addr),
        .b_rd       (b_rd),
        .b_dv       (b_dv),
        .b_data_out (b_data_out),
        .b_wr       (b_wr),
        .b_data_in  (b_data_in),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack),
        .wr_ovf     (wr_ovf)
    );

    always #5 clk = ~clk;

    assign m_rdata = m_addr >> 3;

    // Memory acknowledge pattern: 0 = always, 1 = every third cycle, 2 = random.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        case (ack_mode)
            0:       m_ack = 1'b1;
            1:       m_ack = ((cyc % 3) == 0);
            default: m_ack = 1'($urandom_range(0, 1));
        endcase
    end

    // Beat log, b_dv cycle count and request-stability monitor.
    logic        pend_p = 1'b0;
    logic        we_p;
    logic [63:0] addr_p;
    logic [63:0] wdata_p;
    always @(posedge clk) begin
        if (clr_n) begin
            if (m_req && m_ack) log_q.push_back('{we: m_we, addr: m_addr, wdata: m_wdata});
            if (b_dv) dv_cnt = dv_cnt + 1;
            if (pend_p && m_req && ((m_we !== we_p) || (m_addr !== addr_p) || (m_wdata !== wdata_p)))
                stab_viol = stab_viol + 1;
            pend_p  = m_req && !m_ack;
            we_p    = m_we;
            addr_p  = m_addr;
            wdata_p = m_wdata;
        end else begin
            pend_p = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] mem_line(input logic [63:0] base);
        logic [1023:0] l;
        for (int i = 0; i < 16; i++) l[64*i +: 64] = (base + 64'(8*i)) >> 3;
        return l;
    endfunction

    function automatic logic [1023:0] rand_data();
        logic [1023:0] d;
        for (int i = 0; i < 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [63:0] rand_line();
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[6:0] = 7'd0;
        return a;
    endfunction

    // Compare 16 logged beats starting at log index start against one line.
    task automatic check_beats(input int start, input logic we, input logic [63:0] base,
                               input logic [1023:0] line);
        beat_t e;
        for (int i = 0; i < 16; i++) begin
            e = (start + i < log_q.size()) ? log_q[start + i] : '0;
            chk($sformatf("beat%0d_addr", start + i), e.addr, base + 64'(8*i));
            chk($sformatf("beat%0d_we", start + i), e.we, we);
            if (we) chk($sformatf("beat%0d_wdata", start + i), e.wdata, line[64*i +: 64]);
        end
    endtask

    task automatic wait_dv(input int limit, output int n);
        n = 0;
        while (!b_dv && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("dv_timeout", n < limit, 1'b1);
    endtask

    task automatic wait_log(input int cnt, input int limit);
        int n = 0;
        while (log_q.size() < cnt && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("log_timeout", n < limit, 1'b1);
    endtask

    initial begin
        int            n;
        int            dv0;
        logic [63:0]   la, lb, lc, lx, ly;
        logic [1023:0] d1, d2, d3, dw;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_b_dv", b_dv, 1'b0);
        chk("rst_wr_ovf", wr_ovf, 1'b0);
        chk("rst_b_data_out", b_data_out, '0);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fill with zero wait states: b_dv on the 17th edge
        ack_mode = 0;
        log_q.delete();
        b_addr = 64'h8040;
        b_rd   = 1'b1;
        n = 0;
        while (!b_dv && n < 40) begin
            @(negedge clk);
            n++;
        end
        b_rd = 1'b0;
        chk("fill_latency", 32'(n), 32'd17);
        chk("fill_data", b_data_out, mem_line(64'h8000));
        chk("fill_nbeats", 32'(log_q.size()), 32'd16);
        check_beats(0, 1'b0, 64'h8000, '0);
        repeat (3) @(negedge clk);
        chk("fill_dv_once", 32'(dv_cnt), 32'd1);
        chk("fill_idle", m_req, 1'b0);

        // Write drain
        log_q.delete();
        dv0 = dv_cnt;
        for (int i = 0; i < 16; i++) dw[64*i +: 64] = 64'hA0 + 64'(i);
        b_addr = 64'h4000;
        b_wr   = 1'b1;
        @(negedge clk);
        b_wr      = 1'b0;
        b_data_in = dw;
        wait_log(16, 60);
        repeat (3) @(negedge clk);
        chk("wr_nbeats", 32'(log_q.size()), 32'd16);
        check_beats(0, 1'b1, 64'h4000, dw);
        chk("wr_no_dv", 32'(dv_cnt - dv0), 32'd0);

        // Wait states on a random line, low address bits randomized
        ack_mode = 1;
        log_q.delete();
        stab_viol = 0;
        lx = rand_line();
        b_addr = lx | 64'($urandom_range(0, 127));
        b_rd   = 1'b1;
        wait_dv(200, n);
        b_rd = 1'b0;
        chk("ws_latency_ok", (n >= 46) && (n <= 60), 1'b1);
        chk("ws_data", b_data_out, mem_line(lx));
        chk("ws_stable", 32'(stab_viol), 32'd0);
        check_beats(0, 1'b0, lx, '0);
        repeat (4) @(negedge clk);

        // Ordering and overflow: writes drain before the simultaneous read
        log_q.delete();
        dv0 = dv_cnt;
        la = rand_line();
        lb = rand_line();
        lc = rand_line();
        d1 = rand_data();
        d2 = rand_data();
        d3 = rand_data();
        b_addr = la;
        b_rd   = 1'b1;
        b_wr   = 1'b1;
        @(negedge clk);
        b_wr      = 1'b0;
        b_data_in = d1;
        repeat (10) @(negedge clk);
        b_addr = lb;
        b_wr   = 1'b1;
        @(negedge clk);
        b_wr      = 1'b0;
        b_addr    = la;
        b_data_in = d2;
        repeat (12) @(negedge clk);
        chk("ovf_before", wr_ovf, 1'b0);
        b_addr = lc;
        b_wr   = 1'b1;
        @(negedge clk);
        b_wr      = 1'b0;
        b_addr    = la;
        b_data_in = d3;
        @(negedge clk);
        chk("ovf_set", wr_ovf, 1'b1);
        wait_dv(400, n);
        b_rd = 1'b0;
        chk("ord_data", b_data_out, mem_line(la));
        chk("ord_nbeats", 32'(log_q.size()), 32'd48);
        check_beats(0, 1'b1, la, d1);
        check_beats(16, 1'b1, lb, d2);
        check_beats(32, 1'b0, la, '0);
        repeat (4) @(negedge clk);
        chk("ord_dv_once", 32'(dv_cnt - dv0), 32'd1);

        // Abort: b_rd withdrawn while beat 5 is outstanding
        log_q.delete();
        dv0 = dv_cnt;
        lx = rand_line();
        b_addr = lx;
        b_rd   = 1'b1;
        wait_log(5, 60);
        @(negedge clk);
        b_rd = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_nbeats", 32'(log_q.size()), 32'd6);
        chk("abort_last_addr", (log_q.size() == 6) ? log_q[5].addr : 64'd0, lx + 64'd40);
        chk("abort_no_dv", 32'(dv_cnt - dv0), 32'd0);
        chk("abort_idle", m_req, 1'b0);

        // Readdress before completion: no b_dv for the old line, refetch 0x9000
        ack_mode = 2;
        log_q.delete();
        dv0 = dv_cnt;
        lx = rand_line();
        b_addr = lx;
        b_rd   = 1'b1;
        wait_log(10, 100);
        b_addr = 64'h9000 | 64'($urandom_range(0, 127));
        wait_dv(400, n);
        b_rd = 1'b0;
        chk("readdr_data", b_data_out, mem_line(64'h9000));
        chk("readdr_nbeats", 32'(log_q.size()), 32'd32);
        check_beats(16, 1'b0, 64'h9000, '0);
        repeat (4) @(negedge clk);
        chk("readdr_dv_once", 32'(dv_cnt - dv0), 32'd1);

        // Reset during beat 8 of a fill, then restart from beat 0
        ack_mode = 1;
        log_q.delete();
        lx = rand_line();
        b_addr = lx;
        b_rd   = 1'b1;
        wait_log(8, 100);
        chk("rst_mid_req_before", m_req, 1'b1);
        clr_n = 1'b0;
        #1;
        chk("rst_mid_m_req", m_req, 1'b0);
        chk("rst_mid_b_dv", b_dv, 1'b0);
        chk("rst_mid_wr_ovf", wr_ovf, 1'b0);
        chk("rst_mid_data", b_data_out, '0);
        repeat (2) @(negedge clk);
        log_q.delete();
        ly = rand_line();
        b_addr = ly;
        clr_n  = 1'b1;
        wait_dv(200, n);
        b_rd = 1'b0;
        chk("rst_restart_data", b_data_out, mem_line(ly));
        check_beats(0, 1'b0, ly, '0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
